// File: rtl/bus_source_encoder.sv
// One-hot bus-source enable encoder: produces the bus-mux select code and
// flags multi-driver conflicts with a sticky fault state and saturating counter.
module bus_source_encoder (
  input  logic        clock,
  input  logic        clear,
  input  logic [23:0] out_en,
  input  logic        fault_clr,
  output logic [4:0]  select,
  output logic        bus_valid,
  output logic        conflict,
  output logic [7:0]  conflict_cnt,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    DRIVE = 2'b01,
    FAULT = 2'b10
  } fsm_t;

  fsm_t       cur_state;
  logic [4:0] src_count;
  logic [4:0] src_idx;
  logic       multi;
  logic       single;
  logic       hold_fault;

  function automatic logic [4:0] popcount24(input logic [23:0] v);
    logic [4:0] c;
    c = 5'd0;
    for (int i = 0; i < 24; i++) begin
      c = c + {4'd0, v[i]};
    end
    return c;
  endfunction

  // Scanning from the top down leaves the lowest set index as the winner.
  function automatic logic [4:0] lowest_set(input logic [23:0] v);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = 23; i >= 0; i--) begin
      idx = v[i] ? 5'(i) : idx;
    end
    return idx;
  endfunction

  // Per-edge decode of the enable vector.
  always_comb begin
    src_count  = popcount24(out_en);
    src_idx    = lowest_set(out_en);
    multi      = (src_count >= 5'd2);
    single     = (src_count == 5'd1);
    hold_fault = (cur_state == FAULT) && !fault_clr;
  end

  // FSM with registered select, valid and conflict outputs.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      cur_state    <= IDLE;
      select       <= 5'd0;
      bus_valid    <= 1'b0;
      conflict     <= 1'b0;
      conflict_cnt <= 8'h00;
    end else begin
      case (cur_state)
        IDLE, DRIVE, FAULT: begin
          if (multi) begin
            // A new conflict wins over a simultaneous clear request.
            select       <= src_idx;
            bus_valid    <= 1'b0;
            conflict     <= 1'b1;
            conflict_cnt <= fault_clr ? 8'h01 :
                            ((conflict_cnt == 8'hFF) ? 8'hFF : conflict_cnt + 8'h01);
            cur_state    <= FAULT;
          end else begin
            if (single) begin
              select <= src_idx;
            end else begin
              select <= select;
            end
            bus_valid <= single;
            if (fault_clr) begin
              conflict     <= 1'b0;
              conflict_cnt <= 8'h00;
            end else begin
              conflict     <= conflict;
              conflict_cnt <= conflict_cnt;
            end
            cur_state <= hold_fault ? FAULT : (single ? DRIVE : IDLE);
          end
        end
        default: begin
          cur_state <= IDLE;
          bus_valid <= 1'b0;
        end
      endcase
    end
  end

  assign state = cur_state;

endmodule
